// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared state encoding and PRBS tap set for the checker
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // x^8 + x^6 + x^5 + x^4 + 1
  localparam int PRBS_N = 8;
  localparam int TAP_A  = 8;
  localparam int TAP_B  = 6;
  localparam int TAP_C  = 5;
  localparam int TAP_D  = 4;

  function automatic logic prbs_pred(input logic [1:PRBS_N] sr);
    return sr[TAP_A] ^ sr[TAP_B] ^ sr[TAP_C] ^ sr[TAP_D];
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// rtl/sat_cnt.sv - saturating up-counter with synchronous clear that beats increment
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - PRBS-8 receive checker: fill, self-synchronising search, flywheel lock
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int N        = 8,
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int WIN      = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int FILL_W  = $clog2(N + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);
  localparam int WIN_W   = (WIN > 1) ? $clog2(WIN) : 1;

  state_t              r_state;
  logic [1:N]          r_sr;
  logic [FILL_W-1:0]   r_fill_cnt;
  logic [MATCH_W-1:0]  r_match_cnt;
  logic [MISS_W-1:0]   r_miss_cnt;
  logic [WIN_W-1:0]    r_win_idx;
  logic                r_locked;
  logic                r_err_pulse;

  logic                w_pred;
  logic                w_match;
  logic                w_sr_zero;
  logic                w_chk;
  logic                w_err;
  logic [MISS_W-1:0]   w_miss_nxt;

  assign w_pred     = prbs_pred(r_sr);
  assign w_match    = (din == w_pred);
  assign w_sr_zero  = (r_sr == '0);
  assign w_chk      = din_valid && (r_state == ST_LOCKED);
  assign w_err      = w_chk && !w_match;
  assign w_miss_nxt = r_miss_cnt + MISS_W'(w_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_FILL;
      r_sr        <= '0;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_win_idx   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= w_err;
      if (din_valid) begin
        case (r_state)
          ST_FILL: begin
            r_sr <= {din, r_sr[1:N-1]};
            if (r_fill_cnt == FILL_W'(N - 1)) begin
              r_fill_cnt <= '0;
              r_state    <= ST_SEARCH;
            end else begin
              r_fill_cnt <= r_fill_cnt + 1'b1;
            end
          end
          ST_SEARCH: begin
            r_sr <= {din, r_sr[1:N-1]};
            // an all-zero register predicts zero forever, so a dead line must not count
            if (!w_match || w_sr_zero) begin
              r_match_cnt <= '0;
            end else if (r_match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
              r_match_cnt <= '0;
              r_miss_cnt  <= '0;
              r_win_idx   <= '0;
              r_locked    <= 1'b1;
              r_state     <= ST_LOCKED;
            end else begin
              r_match_cnt <= r_match_cnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            // flywheel: line errors never enter the reference
            r_sr <= {w_pred, r_sr[1:N-1]};
            if (w_miss_nxt == MISS_W'(LOSS_CNT)) begin
              r_match_cnt <= '0;
              r_miss_cnt  <= '0;
              r_win_idx   <= '0;
              r_locked    <= 1'b0;
              r_state     <= ST_SEARCH;
            end else if (r_win_idx == WIN_W'(WIN - 1)) begin
              r_miss_cnt <= '0;
              r_win_idx  <= '0;
            end else begin
              r_miss_cnt <= w_miss_nxt;
              r_win_idx  <= r_win_idx + 1'b1;
            end
          end
          default: begin
            r_state <= ST_FILL;
          end
        endcase
      end
    end
  end

  sat_cnt #(.W(CNT_W)) u_err_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_inc (w_err),
    .i_clr (clr_cnt),
    .o_cnt (err_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_bit_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_inc (w_chk),
    .i_clr (clr_cnt),
    .o_cnt (bit_cnt)
  );

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - scoreboard bench for prbs_checker against a bit-history reference model
module tb_prbs_checker;

  localparam int N    = 8;
  localparam int LOCK = 16;
  localparam int LOSS = 4;
  localparam int WIN  = 64;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam int SEQ_LEN = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          din_valid = 1'b0;
  logic          din = 1'b0;
  logic          clr_cnt = 1'b0;
  logic          locked;
  logic          err_pulse;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] bit_cnt;

  prbs_checker #(
    .N(N), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .WIN(WIN), .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // transmitted stream: s[n] = s[n-8] ^ s[n-6] ^ s[n-5] ^ s[n-4], register seeded with 1
  bit seq[SEQ_LEN];
  int gi = 0;

  // reference model: hist[k-1] is the bit k positions back in the reference
  bit  m_hist[$];
  bit  m_locked;
  int  m_seen, m_run, m_wbits, m_werrs, m_err, m_bits;

  function automatic void model_reset();
    m_hist.delete();
    for (int k = 0; k < N; k++) m_hist.push_back(1'b0);
    m_locked = 1'b0;
    m_seen = 0; m_run = 0; m_wbits = 0; m_werrs = 0; m_err = 0; m_bits = 0;
  endfunction

  function automatic void model_step(input bit v, input bit d, input bit c, output bit pulse);
    bit pred;
    bit all_zero;
    pulse = 1'b0;
    if (v) begin
      pred = m_hist[7] ^ m_hist[5] ^ m_hist[4] ^ m_hist[3];
      if (m_locked) begin
        pulse = (d != pred);
        if (pulse) begin m_err++; m_werrs++; end
        m_bits++;
        if (m_err > CMAX) m_err = CMAX;
        if (m_bits > CMAX) m_bits = CMAX;
        m_wbits++;
        m_hist.push_front(pred);
        if (m_werrs >= LOSS) begin
          m_locked = 1'b0;
          m_run = 0;
        end else if (m_wbits == WIN) begin
          m_wbits = 0;
          m_werrs = 0;
        end
      end else if (m_seen < N) begin
        m_seen++;
        m_hist.push_front(d);
      end else begin
        all_zero = 1'b1;
        foreach (m_hist[k]) if (m_hist[k]) all_zero = 1'b0;
        if (d == pred && !all_zero) m_run++;
        else m_run = 0;
        m_hist.push_front(d);
        if (m_run == LOCK) begin
          m_locked = 1'b1;
          m_run = 0; m_wbits = 0; m_werrs = 0;
        end
      end
      void'(m_hist.pop_back());
    end
    if (c) begin
      m_err = 0;
      m_bits = 0;
    end
  endfunction

  typedef struct {
    bit lk;
    bit pl;
    int ec;
    int bc;
  } exp_t;

  exp_t exp_q[$];

  // monitor: outputs after every active edge are compared with the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_locked",    int'(locked),    int'(e.lk));
        check("sb_err_pulse", int'(err_pulse), int'(e.pl));
        check("sb_err_cnt",   int'(err_cnt),   e.ec);
        check("sb_bit_cnt",   int'(bit_cnt),   e.bc);
      end
    end
  end

  task automatic step(input bit r, input bit v, input bit d, input bit c);
    exp_t e;
    bit   p;
    @(negedge clk);
    rst = r; din_valid = v; din = d; clr_cnt = c;
    if (r) begin
      model_reset();
      p = 1'b0;
    end else begin
      model_step(v, d, c, p);
    end
    e.lk = m_locked; e.pl = p; e.ec = m_err; e.bc = m_bits;
    exp_q.push_back(e);
  endtask

  task automatic send(input bit v, input bit flip, input bit c);
    bit d;
    if (v) begin
      d = seq[gi] ^ flip;
      gi++;
    end else begin
      d = 1'($urandom_range(0, 1));
    end
    step(1'b0, v, d, c);
  endtask

  task automatic send_clean(input int n);
    for (int k = 0; k < n; k++) send(1'b1, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic sync_reset_cycles();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit ever_locked;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (i < N) seq[i] = (i == N - 1);
      else seq[i] = seq[i-8] ^ seq[i-6] ^ seq[i-5] ^ seq[i-4];
    end
    model_reset();

    // reset state
    #1 rst = 1'b1;
    #1;
    check("rst_locked",    int'(locked),    0);
    check("rst_err_pulse", int'(err_pulse), 0);
    check("rst_err_cnt",   int'(err_cnt),   0);
    check("rst_bit_cnt",   int'(bit_cnt),   0);
    sync_reset_cycles();

    // clean stream: lock after valid bit 24, then saturate bit_cnt
    send_clean(23);
    settle();
    check("lock_not_before_24", int'(locked), 0);
    send_clean(1);
    settle();
    check("lock_at_24", int'(locked), 1);
    check("lock_err_cnt", int'(err_cnt), 0);
    send_clean(300);
    settle();
    check("bit_cnt_saturated", int'(bit_cnt), CMAX);

    // single line error
    send(1'b1, 1'b1, 1'b0);
    settle();
    check("single_err_pulse", int'(err_pulse), 1);
    send_clean(1);
    settle();
    check("single_err_pulse_off", int'(err_pulse), 0);
    send_clean(30);
    settle();
    check("single_err_cnt", int'(err_cnt), 1);
    check("single_err_locked", int'(locked), 1);

    // four errors in one window force loss, then relock after 16 clean bits
    sync_reset_cycles();
    send_clean(24);
    settle();
    check("c_locked", int'(locked), 1);
    send_clean(5);
    send(1'b1, 1'b1, 1'b0); send_clean(1);
    send(1'b1, 1'b1, 1'b0); send_clean(1);
    send(1'b1, 1'b1, 1'b0);
    settle();
    check("c_locked_after_3", int'(locked), 1);
    send_clean(1);
    send(1'b1, 1'b1, 1'b0);
    settle();
    check("c_unlock_after_4", int'(locked), 0);
    send_clean(15);
    settle();
    check("c_not_relocked_15", int'(locked), 0);
    send_clean(1);
    settle();
    check("c_relocked_16", int'(locked), 1);
    check("c_err_cnt", int'(err_cnt), 4);

    // stuck-zero line never locks
    sync_reset_cycles();
    ever_locked = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      settle();
      ever_locked |= locked;
    end
    check("zero_line_never_locks", int'(ever_locked), 0);

    // valid one cycle in three
    sync_reset_cycles();
    for (int k = 1; k <= 24; k++) begin
      send(1'b1, 1'b0, 1'b0);
      if (k >= 23) begin
        settle();
        check("sparse_lock", int'(locked), (k == 24) ? 1 : 0);
      end
      send(1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b0, 1'b0);
    end

    // clr_cnt coincident with an error, then asynchronous reset mid-lock
    send_clean(10);
    send(1'b1, 1'b1, 1'b1);
    settle();
    check("clr_err_pulse", int'(err_pulse), 1);
    check("clr_err_cnt", int'(err_cnt), 0);
    check("clr_bit_cnt", int'(bit_cnt), 0);
    send_clean(3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_locked",    int'(locked),    0);
    check("async_err_pulse", int'(err_pulse), 0);
    check("async_err_cnt",   int'(err_cnt),   0);
    check("async_bit_cnt",   int'(bit_cnt),   0);
    model_reset();
    sync_reset_cycles();
    send_clean(23);
    settle();
    check("relock_needs_fill", int'(locked), 0);
    send_clean(1);
    settle();
    check("relock_at_24", int'(locked), 1);

    // randomized traffic with sparse errors and clears
    for (int k = 0; k < 1500; k++) begin
      send(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 99) == 0));
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
